seq_shift_unit: RTL and testbench

SEQ_SHIFT_UNIT -- requirements
Module: seq_shift_unit

---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_step.sv | 26 ++
 rtl/seq_shift_unit.sv | 91 +++++++++
 tb/tb_seq_shift_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared mode and FSM state types for the sequential shifter
package shift_pkg;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROL = 2'b11
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } shift_state_e;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational one-step shifter; the caller bounds amt_i to 0..STEP
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]         data_i,
    input  logic [$clog2(WIDTH):0]   amt_i,
    input  shift_mode_e              mode_i,
    output logic [WIDTH-1:0]         data_o
);

    logic [2*WIDTH-1:0] rot;

    always_comb begin
        // Rotating the doubled word left leaves the rotated result in the upper half.
        rot = {data_i, data_i} << amt_i;
        case (mode_i)
            MODE_SLL: data_o = data_i << amt_i;
            MODE_SRL: data_o = data_i >> amt_i;
            MODE_SRA: data_o = $signed(data_i) >>> amt_i;
            default:  data_o = rot[2*WIDTH-1 -: WIDTH];
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// rtl/seq_shift_unit.sv - multi-cycle shifter applying up to STEP bits per cycle
module seq_shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [1:0]               in_mode,
    input  logic                     abort,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW:0] STEP_W = (SW+1)'(STEP);

    shift_state_e     state_q;
    shift_mode_e      mode_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [SW:0]      rem_q;
    logic [SW:0]      rem_d;
    logic [SW:0]      amt;

    // One extra counter bit lets STEP equal WIDTH without overflowing the compare.
    always_comb begin
        amt   = (rem_q < STEP_W) ? rem_q : STEP_W;
        rem_d = rem_q - amt;
    end

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data_i (data_q),
        .amt_i  (amt),
        .mode_i (mode_q),
        .data_o (data_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_SLL;
            data_q  <= '0;
            rem_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && !abort) begin
                        data_q  <= in_data;
                        mode_q  <= shift_mode_e'(in_mode);
                        rem_q   <= {1'b0, in_shamt};
                        state_q <= (in_shamt == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        data_q  <= '0;
                        rem_q   <= '0;
                    end else begin
                        data_q <= data_d;
                        rem_q  <= rem_d;
                        if (rem_d == '0) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (abort || out_ready) begin
                        state_q <= ST_IDLE;
                        data_q  <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = out_valid ? data_q : '0;

endmodule

// File: tb/tb_seq_shift_unit.sv
// tb/tb_seq_shift_unit.sv - self-checking bench for seq_shift_unit
module tb_seq_shift_unit;

    localparam int WIDTH = 32;
    localparam int STEP  = 4;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        abort     = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data   = '0;
    logic [4:0]  in_shamt  = '0;
    logic [1:0]  in_mode   = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;

    int checks = 0;
    int errors = 0;

    bit          m_busy  = 1'b0;
    bit          m_valid = 1'b0;
    int          m_wait  = 0;
    logic [31:0] m_res   = '0;

    always #5 clk = ~clk;

    seq_shift_unit #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic [1:0] m);
        logic [31:0] r;
        r = d;
        case (m)
            2'd0: r = d << s;
            2'd1: r = d >> s;
            2'd2: for (int i = 0; i < s; i++) r = {d[31], r[31:1]};
            default: for (int i = 0; i < s; i++) r = {r[30:0], r[31]};
        endcase
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Transaction-level model: result known at accept, valid after ceil(shamt/STEP) more edges.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_wait  = 0;
            m_res   = '0;
        end else if (m_valid) begin
            if (abort || out_ready) m_valid = 1'b0;
        end else if (m_busy) begin
            if (abort) begin
                m_busy = 1'b0;
            end else begin
                m_wait--;
                if (m_wait == 0) begin
                    m_busy  = 1'b0;
                    m_valid = 1'b1;
                end
            end
        end else if (in_valid && !abort) begin
            m_res  = ref_shift(in_data, int'(in_shamt), in_mode);
            m_wait = (int'(in_shamt) + STEP - 1) / STEP;
            if (m_wait == 0) m_valid = 1'b1;
            else             m_busy  = 1'b1;
        end
    end

    always @(negedge clk) begin
        check("cyc_in_ready", {31'd0, in_ready}, {31'd0, !m_busy && !m_valid});
        check("cyc_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        check("cyc_out_data", out_data, m_valid ? m_res : 32'd0);
    end

    task automatic do_req(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m,
                          input logic [31:0] exp, input int exp_lat, input string nm);
        int lat;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_mode  = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, "_latency"}, lat, exp_lat);
        check({nm, "_data"}, out_data, exp);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic count_valid(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
    endtask

    initial begin
        int seen;
        int lat;
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_data", out_data, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        do_req(32'h0000_0001, 5'd2, 2'd0, 32'h0000_0004, 2, "sll2");
        do_req(32'h8000_0000, 5'd31, 2'd2, 32'hFFFF_FFFF, 9, "sra31");
        do_req(32'h8000_0000, 5'd31, 2'd1, 32'h0000_0001, 9, "srl31");
        do_req(32'h8000_0001, 5'd4, 2'd3, 32'h0000_0018, 2, "rol4");
        do_req(32'hDEAD_BEEF, 5'd0, 2'd3, 32'hDEAD_BEEF, 1, "shamt0");

        in_valid = 1'b1;
        abort    = 1'b1;
        in_data  = 32'h1111_2222;
        in_shamt = 5'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        abort    = 1'b0;
        check("abort_idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_idle_out_valid", {31'd0, out_valid}, 32'd0);

        in_valid = 1'b1;
        in_data  = 32'h0000_00F0;
        in_shamt = 5'd8;
        in_mode  = 2'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("hold_latency", lat, 3);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data  = $urandom;
            in_shamt = 5'($urandom_range(0, 31));
            @(posedge clk); #1;
            check("hold_data", out_data, 32'h0000_F000);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        check("release_out_valid", {31'd0, out_valid}, 32'd0);

        in_valid = 1'b1;
        in_data  = 32'hA5A5_0F0F;
        in_shamt = 5'd31;
        in_mode  = 2'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        count_valid(12, seen);
        check("abort_no_result", seen, 0);
        do_req(32'h1234_5678, 5'd8, 2'd3, 32'h3456_7812, 3, "after_abort");

        in_valid = 1'b1;
        in_data  = 32'hCAFE_F00D;
        in_shamt = 5'd31;
        in_mode  = 2'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #2;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out_data", out_data, 32'd0);
        #4 rst_n = 1'b1;
        count_valid(15, seen);
        check("midrst_no_stale", seen, 0);
        do_req(32'hF000_000F, 5'd5, 2'd2, 32'hFF80_0000, 3, "after_reset");

        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_data   = $urandom;
            in_shamt  = 5'($urandom_range(0, 31));
            in_mode   = 2'($urandom_range(0, 3));
            abort     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
        end
        check("drain_in_ready", {31'd0, in_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
